lfsr_rng_gen: RTL and testbench

Parametrised successor to the fixed 32-bit random-number generator. It is a Fibonacci XNOR LFSR with these parameters fixed at build time:
- width
- tap mask
- default seed

At run time it adds an explicit seed-load port, a valid/ready output handshake with back-pressure, state retention across idle periods, a full-period counter, and lock-up detection/recovery. It sits between the clock/seed source and consumers such as the RAM logger. Its output is always driven: zero when idle, never high-Z.

---
 rtl/lfsr_rng_pkg.sv | 26 ++
 rtl/lfsr_rng_gen_lfsr_step.sv | 17 +
 rtl/lfsr_rng_gen.sv | 133 +++++++++++++
 tb/tb_lfsr_rng_gen.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_rng_pkg.sv
// Shared types and constants for the parametrised XNOR LFSR random-number generator.
package lfsr_rng_pkg;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  localparam logic [63:0] DefaultTaps = 64'h0000_0000_8020_0003;
  localparam logic [63:0] DefaultSeed = 64'h0000_0000_97AF_C3D0;

  // Maximal-length tap masks in the {lfsr[W-2:0], fb} shift convention; 0 if not tabulated.
  function automatic logic [63:0] max_len_taps(input int unsigned width);
    logic [63:0] taps;
    case (width)
      8:       taps = 64'h0000_0000_0000_00B8;
      16:      taps = 64'h0000_0000_0000_D008;
      24:      taps = 64'h0000_0000_00E1_0000;
      32:      taps = 64'h0000_0000_8020_0003;
      64:      taps = 64'hD800_0000_0000_0000;
      default: taps = 64'h0;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_rng_gen_lfsr_step.sv
// Combinational Fibonacci XNOR LFSR next-state function.
module lfsr_step
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DefaultTaps)
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  logic fb;

  assign fb  = ~^(cur & TAPS);
  assign nxt = {cur[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_rng_gen.sv
// LFSR random-number generator with seed load, valid/ready output, period counter and
// lock-up recovery.
module lfsr_rng_gen
  import lfsr_rng_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter logic [63:0] TAPS         = DefaultTaps,
  parameter logic [63:0] SEED_DEFAULT = DefaultSeed
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [WIDTH-1:0] rnd,
  output logic             busy,
  output logic             seed_err,
  output logic             lockup_err,
  output logic             period_wrap
);

  localparam logic [WIDTH-1:0] Taps    = TAPS[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SeedDef = SEED_DEFAULT[WIDTH-1:0];
  // Last count value before the (2^WIDTH-1)th accepted word.
  localparam logic [WIDTH-1:0] CntLast = {{(WIDTH-1){1'b1}}, 1'b0};

  if (WIDTH < 3 || WIDTH > 64) begin : g_width_check
    $error("lfsr_rng_gen: WIDTH must be in 3..64");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d, lfsr_nxt;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             seed_err_q, seed_err_d;
  logic             lockup_q, lockup_d;
  logic             wrap_q, wrap_d;

  lfsr_step #(
    .WIDTH(WIDTH),
    .TAPS (Taps)
  ) u_step (
    .cur(lfsr_q),
    .nxt(lfsr_nxt)
  );

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    valid_d    = 1'b0;
    seed_err_d = 1'b0;
    lockup_d   = lockup_q;
    wrap_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (seed_valid) begin
          cnt_d = '0;
          if (seed == '1) begin
            lfsr_d     = SeedDef;
            seed_err_d = 1'b1;
          end else begin
            lfsr_d = seed;
          end
        end
        if (req) begin
          state_d = StRun;
          valid_d = 1'b1;
        end
      end
      StRun: begin
        if (lfsr_q == '1) begin
          // Recovery cycle: reload and present nothing until the next cycle.
          lockup_d = 1'b1;
          lfsr_d   = SeedDef;
        end else begin
          if (valid_q && rnd_ready) begin
            lfsr_d = lfsr_nxt;
            if (cnt_q == CntLast) begin
              cnt_d  = '0;
              wrap_d = 1'b1;
            end else begin
              cnt_d = cnt_q + WIDTH'(1);
            end
          end
          valid_d = req;
        end
        if (!req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    rnd_d  = valid_d ? lfsr_d : '0;
    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      lfsr_q     <= SeedDef;
      cnt_q      <= '0;
      rnd_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      seed_err_q <= 1'b0;
      lockup_q   <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      rnd_q      <= rnd_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      seed_err_q <= seed_err_d;
      lockup_q   <= lockup_d;
      wrap_q     <= wrap_d;
    end
  end

  assign rnd_valid   = valid_q;
  assign rnd         = rnd_q;
  assign busy        = busy_q;
  assign seed_err    = seed_err_q;
  assign lockup_err  = lockup_q;
  assign period_wrap = wrap_q;

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Directed self-checking bench for lfsr_rng_gen: default 32-bit build plus a 4-bit build.
module tb_lfsr_rng_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, seed_valid = 1'b0, rnd_ready = 1'b0;
  logic [31:0] seed = '0;
  logic        rnd_valid, busy, seed_err, lockup_err, period_wrap;
  logic [31:0] rnd;

  logic        req4 = 1'b0, ready4 = 1'b0;
  logic        valid4, busy4, seed_err4, lockup4, wrap4;
  logic [3:0]  rnd4;
  logic [3:0]  m_cur = '0;
  logic [3:0]  m_nxt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_rng_gen dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .seed_valid (seed_valid),
    .seed       (seed),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .rnd        (rnd),
    .busy       (busy),
    .seed_err   (seed_err),
    .lockup_err (lockup_err),
    .period_wrap(period_wrap)
  );

  lfsr_rng_gen #(
    .WIDTH(4),
    .TAPS (64'h9)
  ) dut4 (
    .clk        (clk),
    .rst        (rst),
    .req        (req4),
    .seed_valid (1'b0),
    .seed       (4'h0),
    .rnd_valid  (valid4),
    .rnd_ready  (ready4),
    .rnd        (rnd4),
    .busy       (busy4),
    .seed_err   (seed_err4),
    .lockup_err (lockup4),
    .period_wrap(wrap4)
  );

  lfsr_step #(
    .WIDTH(4),
    .TAPS (4'b1001)
  ) u_model (
    .cur(m_cur),
    .nxt(m_nxt)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_vec++;
    if ({rnd_valid, busy, seed_err, lockup_err, period_wrap} !== 5'b0 || rnd !== 32'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b b=%b se=%b le=%b pw=%b rnd=%h, want all 0",
               rnd_valid, busy, seed_err, lockup_err, period_wrap, rnd);
    end
    n_vec++;
    if (dut.lfsr_q !== 32'h97AF_C3D0) begin
      n_err++;
      $display("FAIL reset_lfsr: got %h, want 97afc3d0", dut.lfsr_q);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_seed_zero();
    logic [31:0] exp_seq [5];
    exp_seq = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h9};
    seed = 32'h0; seed_valid = 1'b1; req = 1'b1; rnd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      seed_valid = 1'b0;
      n_vec++;
      if (rnd_valid !== 1'b1 || busy !== 1'b1 || rnd !== exp_seq[i]) begin
        n_err++;
        $display("FAIL seed0_word%0d: got v=%b b=%b rnd=%h, want v=1 b=1 rnd=%h",
                 i, rnd_valid, busy, rnd, exp_seq[i]);
      end
    end
    req = 1'b0; rnd_ready = 1'b0;
    tick();
    n_vec++;
    if (rnd_valid !== 1'b0 || rnd !== 32'h0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_run: got v=%b b=%b rnd=%h, want 0 0 0", rnd_valid, busy, rnd);
    end
  endtask

  task automatic test_seed_err();
    seed = 32'hFFFF_FFFF; seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
    n_vec++;
    if (seed_err !== 1'b1 || rnd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL seed_err_pulse: got se=%b v=%b, want se=1 v=0", seed_err, rnd_valid);
    end
    tick();
    n_vec++;
    if (seed_err !== 1'b0) begin
      n_err++;
      $display("FAIL seed_err_one_cycle: got %b, want 0", seed_err);
    end
    req = 1'b1;
    tick();
    n_vec++;
    if (rnd_valid !== 1'b1 || rnd !== 32'h97AF_C3D0) begin
      n_err++;
      $display("FAIL seed_err_subst: got v=%b rnd=%h, want v=1 rnd=97afc3d0", rnd_valid, rnd);
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_seq [4];
    exp_seq = '{32'h2, 32'h4, 32'h9, 32'h12};
    seed = 32'h0; seed_valid = 1'b1; req = 1'b1; rnd_ready = 1'b1;
    tick();
    seed_valid = 1'b0;
    tick();
    rnd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (rnd_valid !== 1'b1 || rnd !== 32'h1) begin
        n_err++;
        $display("FAIL stall_hold%0d: got v=%b rnd=%h, want v=1 rnd=00000001",
                 i, rnd_valid, rnd);
      end
    end
    rnd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (rnd_valid !== 1'b1 || rnd !== exp_seq[i]) begin
        n_err++;
        $display("FAIL stall_resume%0d: got v=%b rnd=%h, want v=1 rnd=%h",
                 i, rnd_valid, rnd, exp_seq[i]);
      end
    end
    req = 1'b0; rnd_ready = 1'b0;
    tick();
  endtask

  task automatic test_resume();
    seed = 32'h0; seed_valid = 1'b1; req = 1'b1; rnd_ready = 1'b1;
    tick();
    seed_valid = 1'b0;
    tick(); tick(); tick();
    req = 1'b0; rnd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (rnd_valid !== 1'b0 || rnd !== 32'h0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL resume_idle%0d: got v=%b b=%b rnd=%h, want 0 0 0",
                 i, rnd_valid, busy, rnd);
      end
    end
    req = 1'b1;
    tick();
    n_vec++;
    if (rnd_valid !== 1'b1 || rnd !== 32'h4) begin
      n_err++;
      $display("FAIL resume_word: got v=%b rnd=%h, want v=1 rnd=00000004", rnd_valid, rnd);
    end
    // Drop req while accepting: the word is consumed, then idle.
    req = 1'b0; rnd_ready = 1'b1;
    tick();
    n_vec++;
    if (rnd_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drop_with_ready_idle: got v=%b b=%b, want 0 0", rnd_valid, busy);
    end
    req = 1'b1; rnd_ready = 1'b0;
    tick();
    n_vec++;
    if (rnd_valid !== 1'b1 || rnd !== 32'h9) begin
      n_err++;
      $display("FAIL drop_with_ready_adv: got v=%b rnd=%h, want v=1 rnd=00000009",
               rnd_valid, rnd);
    end
  endtask

  task automatic test_lockup();
    // Entered in RUN with rnd_ready low.
    force dut.lfsr_q = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.lfsr_q;
    tick();
    n_vec++;
    if (lockup_err !== 1'b1 || rnd_valid !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL lockup_detect: got le=%b v=%b b=%b, want le=1 v=0 b=1",
               lockup_err, rnd_valid, busy);
    end
    for (int i = 0; i < 4 && rnd_valid !== 1'b1; i++) tick();
    n_vec++;
    if (rnd_valid !== 1'b1 || rnd !== 32'h97AF_C3D0) begin
      n_err++;
      $display("FAIL lockup_reload: got v=%b rnd=%h, want v=1 rnd=97afc3d0", rnd_valid, rnd);
    end
    req = 1'b0;
    tick(); tick();
    n_vec++;
    if (lockup_err !== 1'b1) begin
      n_err++;
      $display("FAIL lockup_sticky: got %b, want 1", lockup_err);
    end
  endtask

  task automatic test_async_reset();
    req = 1'b1; rnd_ready = 1'b1;
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({rnd_valid, busy, lockup_err, period_wrap} !== 4'b0 || rnd !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: got v=%b b=%b le=%b pw=%b rnd=%h, want all 0",
               rnd_valid, busy, lockup_err, period_wrap, rnd);
    end
    rnd_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (rnd_valid !== 1'b1 || rnd !== 32'h97AF_C3D0) begin
      n_err++;
      $display("FAIL restart_seed: got v=%b rnd=%h, want v=1 rnd=97afc3d0", rnd_valid, rnd);
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_period4();
    logic [3:0] hand [6];
    logic [3:0] word0;
    logic       seen [16];
    hand = '{4'h0, 4'h1, 4'h2, 4'h5, 4'hA, 4'h4};
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    m_cur  = 4'h0;
    word0  = 4'h0;
    req4   = 1'b1;
    ready4 = 1'b1;
    tick();
    n_vec++;
    if (valid4 !== 1'b1 || rnd4 !== 4'h0 || busy4 !== 1'b1) begin
      n_err++;
      $display("FAIL w4_first: got v=%b b=%b rnd=%h, want v=1 b=1 rnd=0", valid4, busy4, rnd4);
    end
    seen[0] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      n_vec++;
      if (valid4 !== 1'b1 || rnd4 !== m_nxt) begin
        n_err++;
        $display("FAIL w4_seq%0d: got v=%b rnd=%h, want v=1 rnd=%h", i, valid4, rnd4, m_nxt);
      end
      if (i < 6) begin
        n_vec++;
        if (rnd4 !== hand[i]) begin
          n_err++;
          $display("FAIL w4_hand%0d: got %h, want %h", i, rnd4, hand[i]);
        end
      end
      n_vec++;
      if (wrap4 !== (i == 15 || i == 30)) begin
        n_err++;
        $display("FAIL w4_wrap%0d: got %b, want %b", i, wrap4, (i == 15 || i == 30));
      end
      if (i < 15) begin
        n_vec++;
        if (m_nxt == 4'hF || seen[m_nxt]) begin
          n_err++;
          $display("FAIL w4_unique%0d: got repeat or lock-up word %h, want new state", i, m_nxt);
        end
        seen[m_nxt] = 1'b1;
      end else if (i == 15) begin
        n_vec++;
        if (rnd4 !== word0) begin
          n_err++;
          $display("FAIL w4_period: got %h, want %h", rnd4, word0);
        end
      end
      m_cur = m_nxt;
    end
    n_vec++;
    if (seed_err4 !== 1'b0 || lockup4 !== 1'b0) begin
      n_err++;
      $display("FAIL w4_flags: got se=%b le=%b, want 0 0", seed_err4, lockup4);
    end
    req4 = 1'b0; ready4 = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_seed_zero();
    test_seed_err();
    test_backpressure();
    test_resume();
    test_lockup();
    test_async_reset();
    test_period4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
